// File: rtl/lbist_misr_if.sv
// Response-side LBIST bus: run control, folded core response and go/no-go result.
// With LBIST_XMASK_EN defined the bus also carries a per-bit X mask for the response.
interface lbist_misr_if #(
    parameter int IN_WIDTH   = 32,
    parameter int MISR_WIDTH = 32
);
    logic                  test_mode;
    logic [IN_WIDTH-1:0]   resp_i;
    logic                  resp_valid_i;
`ifdef LBIST_XMASK_EN
    logic [IN_WIDTH-1:0]   resp_mask_i;
`endif
    logic                  busy_o;
    logic                  done_o;
    logic                  go_nogo;
    logic [MISR_WIDTH-1:0] signature_o;

    modport master (
        output test_mode, resp_i, resp_valid_i,
`ifdef LBIST_XMASK_EN
        output resp_mask_i,
`endif
        input  busy_o, done_o, go_nogo, signature_o
    );

    modport slave (
        input  test_mode, resp_i, resp_valid_i,
`ifdef LBIST_XMASK_EN
        input  resp_mask_i,
`endif
        output busy_o, done_o, go_nogo, signature_o
    );
endinterface

// File: rtl/lbist_misr_checker.sv
// LBIST response checker: compacts the core response into a Galois MISR and compares it with a golden signature.
// Optional LBIST_XMASK_EN adds resp_mask_i, whose set bits zero the matching response bits before compaction.
module lbist_misr_checker #(
    parameter int                        IN_WIDTH      = 32,
    parameter int                        MISR_WIDTH    = 32,
    parameter logic [MISR_WIDTH-1:0]     POLY          = 32'h04C11DB7,
    parameter logic [MISR_WIDTH-1:0]     SEED          = 32'hFFFFFFFF,
    parameter int unsigned               WARMUP_CYCLES = 16,
    parameter int unsigned               TEST_CYCLES   = 1024,
    parameter logic [MISR_WIDTH-1:0]     GOLDEN_SIG    = 32'h00000000
) (
    input logic         clk,
    input logic         rst,
    lbist_misr_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        WARMUP,
        COMPACT,
        COMPARE,
        DONE
    } state_e;

    localparam logic [31:0] WARM_LAST = 32'(WARMUP_CYCLES - 1);
    localparam logic [31:0] TEST_LAST = 32'(TEST_CYCLES - 1);

    state_e                state_q;
    logic [31:0]           cnt_q;
    logic [MISR_WIDTH-1:0] sig_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  go_q;
    logic                  tm_q;
    logic                  armed_q;
    logic [IN_WIDTH-1:0]   resp_eff;
    logic [MISR_WIDTH-1:0] misr_d;

    always_comb begin
        resp_eff = bus.resp_i;
`ifdef LBIST_XMASK_EN
        resp_eff = bus.resp_i & ~bus.resp_mask_i;
`endif
        misr_d = {sig_q[MISR_WIDTH-2:0], 1'b0}
               ^ (sig_q[MISR_WIDTH-1] ? POLY : '0)
               ^ MISR_WIDTH'(resp_eff);
    end

    // armed_q demands a sampled low after reset, so a test_mode level held through reset cannot start a run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sig_q   <= SEED;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            go_q    <= 1'b0;
            tm_q    <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            tm_q <= bus.test_mode;
            if (!bus.test_mode) begin
                armed_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (bus.test_mode && !tm_q && armed_q) begin
                        sig_q   <= SEED;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= (WARMUP_CYCLES == 0) ? COMPACT : WARMUP;
                    end
                end
                WARMUP: begin
                    if (!bus.test_mode) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        go_q    <= 1'b0;
                    end else if (bus.resp_valid_i) begin
                        if (cnt_q == WARM_LAST) begin
                            cnt_q   <= '0;
                            state_q <= COMPACT;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                end
                COMPACT: begin
                    if (!bus.test_mode) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        go_q    <= 1'b0;
                    end else if (bus.resp_valid_i) begin
                        sig_q <= misr_d;
                        cnt_q <= cnt_q + 32'd1;
                        if (cnt_q == TEST_LAST) begin
                            state_q <= COMPARE;
                        end
                    end
                end
                COMPARE: begin
                    if (!bus.test_mode) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        go_q    <= 1'b0;
                    end else begin
                        go_q    <= (sig_q == GOLDEN_SIG);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (!bus.test_mode) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                        go_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    go_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.go_nogo     = go_q;
    assign bus.signature_o = sig_q;

endmodule

// File: tb/tb_lbist_misr_checker.sv
// Testbench for lbist_misr_checker: two instances (single-cycle run and warmup/gap run) checked against a software MISR model.
// Expected signatures are queued when stimulus is driven and popped when done_o rises.
module tb_lbist_misr_checker;

    localparam logic [31:0] POLY     = 32'h04C11DB7;
    localparam logic [31:0] SEED     = 32'hFFFFFFFF;
    localparam logic [31:0] GOLDEN_A = 32'hFB3EE249;
    localparam logic [31:0] GOLDEN_B = 32'h00000000;

    logic clk;
    logic rst;

    int tests_run;
    int tests_failed;

    logic [31:0] exp_sig_q[$];
    logic        exp_go_q[$];
    logic [31:0] stream_b[6];

    lbist_misr_if #(.IN_WIDTH(32), .MISR_WIDTH(32)) ifA ();
    lbist_misr_if #(.IN_WIDTH(32), .MISR_WIDTH(32)) ifB ();

    lbist_misr_checker #(
        .IN_WIDTH(32), .MISR_WIDTH(32), .POLY(POLY), .SEED(SEED),
        .WARMUP_CYCLES(0), .TEST_CYCLES(1), .GOLDEN_SIG(GOLDEN_A)
    ) dutA (
        .clk(clk),
        .rst(rst),
        .bus(ifA)
    );

    lbist_misr_checker #(
        .IN_WIDTH(32), .MISR_WIDTH(32), .POLY(POLY), .SEED(SEED),
        .WARMUP_CYCLES(2), .TEST_CYCLES(4), .GOLDEN_SIG(GOLDEN_B)
    ) dutB (
        .clk(clk),
        .rst(rst),
        .bus(ifB)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] r);
        return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done_a(input int budget, output bit seen, output int cycles);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            tick();
            cycles++;
            if (ifA.done_o === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic wait_done_b(input int budget, output bit seen, output int cycles);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            tick();
            cycles++;
            if (ifB.done_o === 1'b1) seen = 1'b1;
        end
    endtask

    // Starts dutB and feeds stream_b with continuous valid; queues the model result.
    task automatic run_b_continuous();
        logic [31:0] s;
        ifB.test_mode    = 1'b0;
        ifB.resp_valid_i = 1'b0;
        tick();
        ifB.test_mode = 1'b1;
        tick();
        s = SEED;
        for (int i = 0; i < 6; i++) begin
            ifB.resp_i       = stream_b[i];
            ifB.resp_valid_i = 1'b1;
            tick();
            if (i >= 2) s = misr_step(s, stream_b[i]);
        end
        ifB.resp_valid_i = 1'b0;
        exp_sig_q.push_back(s);
        exp_go_q.push_back(s == GOLDEN_B);
    endtask

    task automatic pop_check_b(input string name);
        logic [31:0] es;
        logic        eg;
        es = exp_sig_q.pop_front();
        eg = exp_go_q.pop_front();
        tests_run++;
        if (ifB.signature_o !== es) begin
            tests_failed++;
            $display("[TB] FAIL %s_sig: got %h expected %h", name, ifB.signature_o, es);
        end
        tests_run++;
        if (ifB.go_nogo !== eg) begin
            tests_failed++;
            $display("[TB] FAIL %s_go: got %b expected %b", name, ifB.go_nogo, eg);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        tests_run++;
        if ({ifA.busy_o, ifA.done_o, ifA.go_nogo} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags_a: got %b expected 000", {ifA.busy_o, ifA.done_o, ifA.go_nogo});
        end
        tests_run++;
        if (ifA.signature_o !== SEED) begin
            tests_failed++;
            $display("[TB] FAIL reset_sig_a: got %h expected %h", ifA.signature_o, SEED);
        end
        tests_run++;
        if ({ifB.busy_o, ifB.done_o, ifB.go_nogo} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags_b: got %b expected 000", {ifB.busy_o, ifB.done_o, ifB.go_nogo});
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single(input logic [31:0] resp, input string name);
        logic [31:0] es;
        logic        eg;
        ifA.test_mode    = 1'b0;
        ifA.resp_i       = resp;
        ifA.resp_valid_i = 1'b1;
        tick();
        es = misr_step(SEED, resp);
        exp_sig_q.push_back(es);
        exp_go_q.push_back(es == GOLDEN_A);
        ifA.test_mode = 1'b1;
        tick();
        tests_run++;
        if (ifA.busy_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL %s_busy_e0: got %b expected 1", name, ifA.busy_o);
        end
        tick();
        tests_run++;
        if (ifA.done_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s_done_early: got %b expected 0", name, ifA.done_o);
        end
        tick();
        tests_run++;
        if (ifA.done_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL %s_done_latency: got %b expected 1", name, ifA.done_o);
        end
        es = exp_sig_q.pop_front();
        eg = exp_go_q.pop_front();
        tests_run++;
        if (ifA.signature_o !== es) begin
            tests_failed++;
            $display("[TB] FAIL %s_sig: got %h expected %h", name, ifA.signature_o, es);
        end
        tests_run++;
        if (ifA.go_nogo !== eg) begin
            tests_failed++;
            $display("[TB] FAIL %s_go: got %b expected %b", name, ifA.go_nogo, eg);
        end
        ifA.test_mode = 1'b0;
        tick();
        tests_run++;
        if ({ifA.done_o, ifA.go_nogo, ifA.signature_o} !== {2'b00, es}) begin
            tests_failed++;
            $display("[TB] FAIL %s_release: got %b%b %h expected 00 %h",
                     name, ifA.done_o, ifA.go_nogo, ifA.signature_o, es);
        end
    endtask

    task automatic test_valid_gaps();
        logic [31:0] s;
        int          warm;
        int          comp;
        int          k;
        bit          seen;
        int          cycles;
        ifB.test_mode    = 1'b0;
        ifB.resp_valid_i = 1'b0;
        tick();
        ifB.test_mode = 1'b1;
        tick();
        s    = SEED;
        warm = 0;
        comp = 0;
        k    = 0;
        while (comp < 4 && k < 40) begin
            ifB.resp_valid_i = (k % 2 == 0);
            ifB.resp_i       = 32'hA5A50000 + 32'(k);
            tick();
            if (ifB.resp_valid_i) begin
                if (warm < 2) warm++;
                else begin
                    s = misr_step(s, ifB.resp_i);
                    comp++;
                end
            end
            tests_run++;
            if (ifB.done_o !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL gaps_done_early k=%0d: got %b expected 0", k, ifB.done_o);
            end
            k++;
        end
        ifB.resp_valid_i = 1'b0;
        exp_sig_q.push_back(s);
        exp_go_q.push_back(s == GOLDEN_B);
        wait_done_b(8, seen, cycles);
        tests_run++;
        if (!seen || cycles != 1) begin
            tests_failed++;
            $display("[TB] FAIL gaps_done_latency: got seen=%b cycles=%0d expected seen=1 cycles=1", seen, cycles);
        end
        pop_check_b("gaps");
        ifB.test_mode = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        bit seen;
        int cycles;
        for (int i = 0; i < 6; i++) stream_b[i] = $urandom;
        ifB.test_mode    = 1'b0;
        ifB.resp_valid_i = 1'b0;
        tick();
        ifB.test_mode = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            ifB.resp_i       = stream_b[i];
            ifB.resp_valid_i = 1'b1;
            tick();
        end
        ifB.test_mode = 1'b0;
        ifB.resp_i    = stream_b[4];
        tick();
        tests_run++;
        if ({ifB.busy_o, ifB.done_o, ifB.go_nogo} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL abort_flags: got %b expected 000", {ifB.busy_o, ifB.done_o, ifB.go_nogo});
        end
        tick();
        tick();
        tests_run++;
        if (ifB.done_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_no_result: got %b expected 0", ifB.done_o);
        end
        run_b_continuous();
        wait_done_b(8, seen, cycles);
        tests_run++;
        if (seen !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL abort_restart_timeout: got %b expected 1", seen);
        end
        pop_check_b("abort_restart");
        ifB.test_mode = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        bit seen;
        int cycles;
        for (int i = 0; i < 6; i++) stream_b[i] = $urandom;
        ifB.test_mode    = 1'b0;
        ifB.resp_valid_i = 1'b0;
        tick();
        ifB.test_mode = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            ifB.resp_i       = stream_b[i];
            ifB.resp_valid_i = 1'b1;
            tick();
        end
        #3;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({ifB.busy_o, ifB.done_o, ifB.go_nogo, ifB.signature_o} !== {3'b000, SEED}) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got %b%b%b %h expected 000 %h",
                     ifB.busy_o, ifB.done_o, ifB.go_nogo, ifB.signature_o, SEED);
        end
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (ifB.busy_o !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL held_mode_retrigger c=%0d: got %b expected 0", i, ifB.busy_o);
            end
        end
        run_b_continuous();
        wait_done_b(8, seen, cycles);
        tests_run++;
        if (seen !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_rerun_timeout: got %b expected 1", seen);
        end
        pop_check_b("reset_rerun");
        ifB.test_mode = 1'b0;
        tick();
    endtask

`ifdef LBIST_XMASK_EN
    task automatic test_xmask();
        bit seen;
        int cycles;
        ifA.test_mode    = 1'b0;
        ifA.resp_i       = $urandom | 32'h1;
        ifA.resp_mask_i  = 32'hFFFFFFFF;
        ifA.resp_valid_i = 1'b1;
        tick();
        ifA.test_mode = 1'b1;
        wait_done_a(8, seen, cycles);
        tests_run++;
        if (seen !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL xmask_timeout: got %b expected 1", seen);
        end
        tests_run++;
        if (ifA.signature_o !== 32'hFB3EE249) begin
            tests_failed++;
            $display("[TB] FAIL xmask_sig: got %h expected FB3EE249", ifA.signature_o);
        end
        ifA.test_mode   = 1'b0;
        ifA.resp_mask_i = 32'h0;
        tick();
    endtask
`endif

    initial begin
        clk              = 1'b0;
        rst              = 1'b1;
        tests_run        = 0;
        tests_failed     = 0;
        ifA.test_mode    = 1'b0;
        ifA.resp_i       = '0;
        ifA.resp_valid_i = 1'b0;
        ifB.test_mode    = 1'b0;
        ifB.resp_i       = '0;
        ifB.resp_valid_i = 1'b0;
`ifdef LBIST_XMASK_EN
        ifA.resp_mask_i  = '0;
        ifB.resp_mask_i  = '0;
`endif
        test_reset();
        test_single(32'h0, "single_zero");
        test_single(32'h1, "single_one");
        test_valid_gaps();
        test_abort();
        test_async_reset();
`ifdef LBIST_XMASK_EN
        test_xmask();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
